display_code_driver: RTL

DISPLAY_CODE_DRIVER -- requirements
Module: display_code_driver

---
 rtl/display_code_driver.sv | 264 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/display_code_driver.sv
// display_code_driver
//
// Converts a binary time-of-day (hour/minute/second) into seven 4-bit display
// digit codes using a small sequential BCD converter. The converter peels off
// one ten per clock. A blink generator produces per-digit enables so that the
// field currently being edited flashes.
//
// Digit codes: 0-9 decimal, 10 blank, 11 dash, 12 "A", 13 "P".
//
// Ports:
//   clk        system clock, all state on rising edge
//   nReset     asynchronous active-low reset
//   load       one-cycle strobe, latches the time fields and starts a conversion
//              (ignored while busy)
//   hour       binary hour, legal 0-23
//   minute     binary minute, legal 0-59
//   second     binary second, legal 0-59
//   mode24     1 = 24-hour display, 0 = 12-hour display with AM/PM digit
//   editField  field that blinks: 0 none, 1 hour, 2 minute, 3 second
//   alarmUnset (only with ALARM_DASH_EN) show dashes instead of the time
//   digitCode  {AM/PM, hourTens, hourOnes, minTens, minOnes, secTens, secOnes}
//   digitOn    per-digit enable, same order as digitCode (bit 6 = AM/PM)
//   busy       conversion in progress
//   done       one-cycle pulse when a new digitCode is committed
//   rangeErr   last committed load had an out-of-range field
//
// Configuration macro: ALARM_DASH_EN adds the alarmUnset input.

module display_code_driver #(
    parameter int BLINK_HALF = 25000000
) (
    input  logic        clk,
    input  logic        nReset,
    input  logic        load,
    input  logic [4:0]  hour,
    input  logic [5:0]  minute,
    input  logic [5:0]  second,
    input  logic        mode24,
    input  logic [1:0]  editField,
`ifdef ALARM_DASH_EN
    input  logic        alarmUnset,
`endif
    output logic [27:0] digitCode,
    output logic [6:0]  digitOn,
    output logic        busy,
    output logic        done,
    output logic        rangeErr
);

    localparam int CW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
    localparam logic [CW-1:0] BLINK_LAST = CW'(BLINK_HALF - 1);

    typedef enum logic [2:0] {
        IDLE,
        CONV_H,
        CONV_M,
        CONV_S,
        COMMIT
    } state_t;

    state_t stateNow;
    state_t stateNext;

    logic [4:0]  hVal;
    logic [5:0]  mVal;
    logic [5:0]  sVal;
    logic [1:0]  hTens;
    logic [2:0]  mTens;
    logic [2:0]  sTens;
    logic        pmFlag;
    logic        mode24Lat;
    logic        hErr;
    logic        mErr;
    logic        sErr;

    logic [4:0]  hourMapped;
    logic [27:0] commitCode;
    logic        commitRange;

    logic [CW-1:0] blinkCount;
    logic          blinkPhase;
    logic [1:0]    prevEditField;

    // State register.
    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            stateNow <= IDLE;
        end else begin
            stateNow <= stateNext;
        end
    end

    // Next-state logic: each CONV state stays put while its value still holds
    // a ten to remove, then hands over to the next field.
    always_comb begin
        stateNext = stateNow;
        case (stateNow)
            IDLE:    if (load)             stateNext = CONV_H;
            CONV_H:  if (hVal < 5'd10)     stateNext = CONV_M;
            CONV_M:  if (mVal < 6'd10)     stateNext = CONV_S;
            CONV_S:  if (sVal < 6'd10)     stateNext = COMMIT;
            COMMIT:                        stateNext = IDLE;
            default:                       stateNext = IDLE;
        endcase
    end

    assign busy = (stateNow != IDLE);

    // 12-hour folding happens at latch time. Out-of-range hours are kept raw
    // because they are displayed as dashes anyway.
    always_comb begin
        hourMapped = hour;
        if (!mode24 && hour <= 5'd23) begin
            if (hour == 5'd0) begin
                hourMapped = 5'd12;
            end else if (hour > 5'd12) begin
                hourMapped = hour - 5'd12;
            end
        end
    end

    // Assemble the committed digit codes from the converted tens/ones.
    // After conversion every *Val register holds only the ones digit.
    always_comb begin
        logic [3:0] apCode;
        logic [3:0] hTensCode;
        logic [3:0] hOnesCode;
        logic [3:0] mTensCode;
        logic [3:0] mOnesCode;
        logic [3:0] sTensCode;
        logic [3:0] sOnesCode;

        apCode    = mode24Lat ? 4'd10 : (pmFlag ? 4'd13 : 4'd12);
        hTensCode = (hTens == 2'd0) ? 4'd10 : {2'b00, hTens};
        hOnesCode = hVal[3:0];
        mTensCode = {1'b0, mTens};
        mOnesCode = mVal[3:0];
        sTensCode = {1'b0, sTens};
        sOnesCode = sVal[3:0];

        if (hErr) begin
            hTensCode = 4'd11;
            hOnesCode = 4'd11;
        end
        if (mErr) begin
            mTensCode = 4'd11;
            mOnesCode = 4'd11;
        end
        if (sErr) begin
            sTensCode = 4'd11;
            sOnesCode = 4'd11;
        end

        commitCode  = {apCode, hTensCode, hOnesCode, mTensCode, mOnesCode,
                       sTensCode, sOnesCode};
        commitRange = hErr | mErr | sErr;

`ifdef ALARM_DASH_EN
        // An unset alarm shows all dashes and leaves the error flag alone.
        if (alarmUnset) begin
            commitCode  = {4'd10, {6{4'd11}}};
            commitRange = rangeErr;
        end
`endif
    end

    // Conversion datapath and committed outputs.
    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            hVal      <= '0;
            mVal      <= '0;
            sVal      <= '0;
            hTens     <= '0;
            mTens     <= '0;
            sTens     <= '0;
            pmFlag    <= 1'b0;
            mode24Lat <= 1'b0;
            hErr      <= 1'b0;
            mErr      <= 1'b0;
            sErr      <= 1'b0;
            digitCode <= 28'hAAAAAAA;
            done      <= 1'b0;
            rangeErr  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (stateNow)
                IDLE: begin
                    if (load) begin
                        hVal      <= hourMapped;
                        mVal      <= minute;
                        sVal      <= second;
                        hTens     <= '0;
                        mTens     <= '0;
                        sTens     <= '0;
                        pmFlag    <= (hour >= 5'd12);
                        mode24Lat <= mode24;
                        hErr      <= (hour > 5'd23);
                        mErr      <= (minute > 6'd59);
                        sErr      <= (second > 6'd59);
                    end
                end
                CONV_H: begin
                    if (hVal >= 5'd10) begin
                        hVal  <= hVal - 5'd10;
                        hTens <= hTens + 2'd1;
                    end
                end
                CONV_M: begin
                    if (mVal >= 6'd10) begin
                        mVal  <= mVal - 6'd10;
                        mTens <= mTens + 3'd1;
                    end
                end
                CONV_S: begin
                    if (sVal >= 6'd10) begin
                        sVal  <= sVal - 6'd10;
                        sTens <= sTens + 3'd1;
                    end
                end
                COMMIT: begin
                    digitCode <= commitCode;
                    rangeErr  <= commitRange;
                    done      <= 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    // Blink generator. A change of editField restarts the visible half so the
    // newly selected field is shown immediately.
    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            blinkCount    <= '0;
            blinkPhase    <= 1'b1;
            prevEditField <= 2'd0;
        end else begin
            prevEditField <= editField;
            if (editField != prevEditField) begin
                blinkCount <= '0;
                blinkPhase <= 1'b1;
            end else if (blinkCount == BLINK_LAST) begin
                blinkCount <= '0;
                blinkPhase <= ~blinkPhase;
            end else begin
                blinkCount <= blinkCount + 1'b1;
            end
        end
    end

    // Only the two digits of the edited field follow the blink phase;
    // the AM/PM digit never blinks.
    always_comb begin
        digitOn = 7'b1111111;
        case (editField)
            2'd1:    digitOn[5:4] = {2{blinkPhase}};
            2'd2:    digitOn[3:2] = {2{blinkPhase}};
            2'd3:    digitOn[1:0] = {2{blinkPhase}};
            default: digitOn = 7'b1111111;
        endcase
    end

endmodule
